uart_rx_os: RTL and testbench



---
 rtl/uart_rx_os.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_os.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: 2-flop line sync, start/data/stop FSM, break hold-off.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done,
  output logic            o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            o_parity_err
`endif
);

  localparam int unsigned NW = $clog2(DBIT);
  localparam int unsigned SW = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic            r_rx_meta, r_rx_s;
  logic [2:0]      r_state, w_state_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [NW-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0] r_b, w_b_nxt;
  logic [DBIT-1:0] r_dout, w_dout_nxt;
  logic            r_done, w_done_nxt;
  logic            r_ferr, w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic            r_par, w_par_nxt;
  logic            r_perr, w_perr_nxt;
`endif

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_n       <= '0;
      r_b       <= '0;
      r_dout    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_nxt;
      r_s       <= w_s_nxt;
      r_n       <= w_n_nxt;
      r_b       <= w_b_nxt;
      r_dout    <= w_dout_nxt;
      r_done    <= w_done_nxt;
      r_ferr    <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par     <= w_par_nxt;
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  // Next-state and output logic; IDLE and BREAK react without a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = r_ferr;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = r_perr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = ST_START;
          w_s_nxt     = '0;
        end
      end
      ST_START: begin
        if (i_s_tick) begin
          if (r_s == SW'(7)) begin
            w_s_nxt = '0;
            if (!r_rx_s) begin
              w_state_nxt = ST_DATA;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_s_tick) begin
          if (r_s == SW'(15)) begin
            w_s_nxt = '0;
            w_b_nxt = {r_rx_s, r_b[DBIT-1:1]};
            if (r_n == NW'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end else begin
              w_n_nxt = r_n + NW'(1);
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_s_tick) begin
          if (r_s == SW'(15)) begin
            w_s_nxt     = '0;
            w_par_nxt   = r_rx_s;
            w_state_nxt = ST_STOP;
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_s_tick) begin
          if (r_s == SW'(SB_TICK-1)) begin
            w_s_nxt     = '0;
            w_dout_nxt  = r_b;
            w_ferr_nxt  = ~r_rx_s;
            w_done_nxt  = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt  = (^r_b) ^ r_par ^ 1'(PARITY_ODD);
`endif
            w_state_nxt = r_rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end
      ST_BREAK: begin
        // A line stuck low must return high before another frame is accepted.
        if (r_rx_s) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_s_nxt     = '0;
        w_n_nxt     = '0;
      end
    endcase
  end

  assign o_dout      = r_dout;
  assign o_rx_done   = r_done;
  assign o_frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus random frames vs a frame-level model.
module tb_uart_rx_os;

  localparam int unsigned BIT_CLKS = 256;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_s_tick = 1'b0;
  logic [7:0] o_dout;
  logic       o_rx_done;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  uart_rx_os dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx       (i_rx),
    .i_s_tick   (i_s_tick),
    .o_dout     (o_dout),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     got_q[$];
  logic [7:0] last_d = 8'h00;
  logic       last_fe = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tick generator: one-cycle pulse every 16 clocks.
  initial begin
    forever begin
      repeat (15) @(negedge i_clk);
      i_s_tick = 1'b1;
      @(negedge i_clk);
      i_s_tick = 1'b0;
    end
  end

  // Capture every completion pulse.
  always @(negedge i_clk) begin
    if (o_rx_done === 1'b1) begin
      frame_t f;
      f.d  = o_dout;
      f.fe = o_frame_err;
`ifdef UART_RX_PARITY_EN
      f.pe = o_parity_err;
`else
      f.pe = 1'b0;
`endif
      got_q.push_back(f);
    end
  end

  task automatic send_bit(input logic v);
    i_rx = v;
    repeat (BIT_CLKS) @(negedge i_clk);
  endtask

  // Model: every complete frame yields one entry with data, ~stop and the parity verdict.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    frame_t f;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
    f.pe = bad_par;
`else
    f.pe = 1'b0;
`endif
    send_bit(stop);
    f.d  = d;
    f.fe = ~stop;
    exp_q.push_back(f);
  endtask

  task automatic verify(input string tag);
    int n;
    repeat (64) @(negedge i_clk);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_dout"}, 32'(got_q[i].d), 32'(exp_q[i].d));
      check({tag, "_ferr"}, 32'(got_q[i].fe), 32'(exp_q[i].fe));
`ifdef UART_RX_PARITY_EN
      check({tag, "_perr"}, 32'(got_q[i].pe), 32'(exp_q[i].pe));
`endif
    end
    if (exp_q.size() > 0) begin
      last_d  = exp_q[exp_q.size()-1].d;
      last_fe = exp_q[exp_q.size()-1].fe;
    end
    check({tag, "_held_dout"}, 32'(o_dout), 32'(last_d));
    check({tag, "_held_ferr"}, 32'(o_frame_err), 32'(last_fe));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       bp;
    int         gap;

    repeat (4) @(negedge i_clk);
    check("rst_dout", 32'(o_dout), 32'h0);
    check("rst_done", 32'(o_rx_done), 32'h0);
    check("rst_ferr", 32'(o_frame_err), 32'h0);
    i_reset = 1'b1;
    send_bit(1'b1);

    send_frame(8'hA5, 1'b1, 1'b0);
    send_bit(1'b1);
    verify("a5");

    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    send_bit(1'b1);
    verify("b2b");

    i_rx = 1'b0;
    repeat (64) @(negedge i_clk);
    send_bit(1'b1);
    send_bit(1'b1);
    verify("glitch");

    send_frame(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    verify("break");
    send_bit(1'b1);
    send_frame(8'h0F, 1'b1, 1'b0);
    send_bit(1'b1);
    verify("after_break");

    // Abort 0xFF mid data bit 4 with reset.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i_rx = 1'b1;
    repeat (100) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    check("abort_rst_dout", 32'(o_dout), 32'h0);
    check("abort_rst_ferr", 32'(o_frame_err), 32'h0);
    i_reset = 1'b1;
    last_d  = 8'h00;
    last_fe = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1);
    verify("abort");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1);
    verify("par_ok");
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    verify("par_bad");
`endif

    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      bp   = 1'($urandom_range(0, 1));
`else
      bp   = 1'b0;
`endif
      gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(d, stop, bp);
      for (int g = 0; g < gap; g++) send_bit(1'b1);
    end
    send_bit(1'b1);
    verify("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
